// File: rtl/sap_core.sv
// sap_core: multi-cycle accumulator CPU in the SAP-1 lineage.
//
// Datapath: PC, MAR, IR, A, B, ALU with carry/zero flags, output register,
// internal 2**ADDR_W x DATA_W RAM, and a hardwired controller FSM. The RAM is
// loaded through the prog_* port while the core is idle or halted. A pulse on
// run then starts execution from PC = 0.
//
// Optional feature: define SAP_CORE_MUL_EN to enable opcode 8 (MUL), a
// DATA_W-cycle shift-add multiply. Without it, opcode 8 decodes as a NOP.
//
// Parameters:
//   DATA_W    data/instruction width (must be >= 4 + ADDR_W)
//   ADDR_W    address width; RAM depth is 2**ADDR_W
//
// Ports:
//   CLK        rising-edge clock
//   CLR        synchronous active-high reset (RAM contents are kept)
//   run        start request, sampled only in IDLE
//   prog_we    RAM write strobe, honoured only in IDLE or HALT
//   prog_addr  RAM write address
//   prog_data  RAM write data
//   out_data   output register written by OUT
//   out_valid  one-cycle pulse when out_data is updated
//   halted     high in HALT
//   busy       high in any state other than IDLE/HALT
//   pc_dbg     current program counter
//   carry      carry flag
//   zero       zero flag
module sap_core #(
  parameter int unsigned DATA_W = 8,
  parameter int unsigned ADDR_W = 4
) (
  input  logic              CLK,
  input  logic              CLR,
  input  logic              run,
  input  logic              prog_we,
  input  logic [ADDR_W-1:0] prog_addr,
  input  logic [DATA_W-1:0] prog_data,
  output logic [DATA_W-1:0] out_data,
  output logic              out_valid,
  output logic              halted,
  output logic              busy,
  output logic [ADDR_W-1:0] pc_dbg,
  output logic              carry,
  output logic              zero
);

  localparam int unsigned Depth = 2 ** ADDR_W;

  localparam logic [3:0] OpLda = 4'h0;
  localparam logic [3:0] OpAdd = 4'h1;
  localparam logic [3:0] OpSub = 4'h2;
  localparam logic [3:0] OpSta = 4'h3;
  localparam logic [3:0] OpLdi = 4'h4;
  localparam logic [3:0] OpJmp = 4'h5;
  localparam logic [3:0] OpJc  = 4'h6;
  localparam logic [3:0] OpJz  = 4'h7;
`ifdef SAP_CORE_MUL_EN
  localparam logic [3:0] OpMul = 4'h8;
`endif
  localparam logic [3:0] OpOut = 4'hE;
  localparam logic [3:0] OpHlt = 4'hF;

  typedef enum logic [2:0] {
    StIdle,
    StFetch1,
    StFetch2,
    StExec1,
    StExec2,
    StExec3,
    StHalt
`ifdef SAP_CORE_MUL_EN
    , StMul
`endif
  } state_e;

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] pc_q, pc_d;
  logic [ADDR_W-1:0] mar_q, mar_d;
  logic [DATA_W-1:0] ir_q, ir_d;
  logic [DATA_W-1:0] a_q, a_d;
  logic [DATA_W-1:0] b_q, b_d;
  logic              carry_q, carry_d;
  logic              zero_q, zero_d;
  logic [DATA_W-1:0] out_q, out_d;
  logic              out_valid_q, out_valid_d;

  logic [DATA_W-1:0] mem [Depth];
  logic              ram_we;
  logic [ADDR_W-1:0] ram_waddr;
  logic [DATA_W-1:0] ram_wdata;
  logic [DATA_W-1:0] ram_rd;

  logic [3:0]        opcode;
  logic [ADDR_W-1:0] operand;
  logic [DATA_W-1:0] imm;
  logic [DATA_W:0]   sum;
  logic [DATA_W:0]   diff;

`ifdef SAP_CORE_MUL_EN
  localparam int unsigned CntW = $clog2(DATA_W + 1);

  logic [2*DATA_W-1:0] mul_acc_q, mul_acc_d;
  logic [2*DATA_W-1:0] mul_mcand_q, mul_mcand_d;
  logic [DATA_W-1:0]   mul_mplier_q, mul_mplier_d;
  logic [CntW-1:0]     mul_cnt_q, mul_cnt_d;
  logic [2*DATA_W-1:0] mul_acc_next;
`endif

  // Asynchronous array read; the address always comes from MAR, which was
  // loaded one state earlier, so the access behaves as a registered read.
  assign ram_rd  = mem[mar_q];
  assign opcode  = ir_q[DATA_W-1 -: 4];
  assign operand = ir_q[ADDR_W-1:0];
  assign imm     = {{(DATA_W - ADDR_W){1'b0}}, operand};
  assign sum     = {1'b0, a_q} + {1'b0, b_q};
  assign diff    = {1'b0, a_q} - {1'b0, b_q};

  always_comb begin
    state_d     = state_q;
    pc_d        = pc_q;
    mar_d       = mar_q;
    ir_d        = ir_q;
    a_d         = a_q;
    b_d         = b_q;
    carry_d     = carry_q;
    zero_d      = zero_q;
    out_d       = out_q;
    out_valid_d = 1'b0;
    ram_we      = 1'b0;
    ram_waddr   = prog_addr;
    ram_wdata   = prog_data;
`ifdef SAP_CORE_MUL_EN
    mul_acc_d    = mul_acc_q;
    mul_mcand_d  = mul_mcand_q;
    mul_mplier_d = mul_mplier_q;
    mul_cnt_d    = mul_cnt_q;
    mul_acc_next = mul_acc_q + (mul_mplier_q[0] ? mul_mcand_q : '0);
`endif

    // External loading is only allowed while the core is not executing.
    if (prog_we && (state_q == StIdle || state_q == StHalt)) begin
      ram_we = 1'b1;
    end

    unique case (state_q)
      StIdle: begin
        if (run) state_d = StFetch1;
      end

      StFetch1: begin
        mar_d   = pc_q;
        state_d = StFetch2;
      end

      StFetch2: begin
        ir_d    = ram_rd;
        pc_d    = pc_q + ADDR_W'(1);
        state_d = StExec1;
      end

      StExec1: begin
        state_d = StFetch1;
        case (opcode)
`ifdef SAP_CORE_MUL_EN
          OpMul,
`endif
          OpLda, OpAdd, OpSub, OpSta: begin
            mar_d   = operand;
            state_d = StExec2;
          end
          OpLdi: begin
            a_d    = imm;
            zero_d = (imm == '0);
          end
          OpJmp: pc_d = operand;
          OpJc:  if (carry_q) pc_d = operand;
          OpJz:  if (zero_q) pc_d = operand;
          OpOut: begin
            out_d       = a_q;
            out_valid_d = 1'b1;
          end
          OpHlt: state_d = StHalt;
          default: ;
        endcase
      end

      StExec2: begin
        state_d = StFetch1;
        case (opcode)
          OpLda: begin
            a_d    = ram_rd;
            zero_d = (ram_rd == '0);
          end
          OpSta: begin
            // A reset arriving on this edge aborts the store.
            ram_we    = !CLR;
            ram_waddr = mar_q;
            ram_wdata = a_q;
          end
          OpAdd, OpSub: begin
            b_d     = ram_rd;
            state_d = StExec3;
          end
`ifdef SAP_CORE_MUL_EN
          OpMul: begin
            b_d          = ram_rd;
            mul_acc_d    = '0;
            mul_mcand_d  = {{DATA_W{1'b0}}, a_q};
            mul_mplier_d = ram_rd;
            mul_cnt_d    = '0;
            state_d      = StMul;
          end
`endif
          default: ;
        endcase
      end

      StExec3: begin
        state_d = StFetch1;
        if (opcode == OpSub) begin
          a_d     = diff[DATA_W-1:0];
          carry_d = ~diff[DATA_W];
          zero_d  = (diff[DATA_W-1:0] == '0);
        end else begin
          a_d     = sum[DATA_W-1:0];
          carry_d = sum[DATA_W];
          zero_d  = (sum[DATA_W-1:0] == '0);
        end
      end

`ifdef SAP_CORE_MUL_EN
      StMul: begin
        // One multiplier bit per cycle, LSB first.
        mul_acc_d    = mul_acc_next;
        mul_mcand_d  = mul_mcand_q << 1;
        mul_mplier_d = mul_mplier_q >> 1;
        mul_cnt_d    = mul_cnt_q + CntW'(1);
        if (mul_cnt_q == CntW'(DATA_W - 1)) begin
          a_d     = mul_acc_next[DATA_W-1:0];
          carry_d = |mul_acc_next[2*DATA_W-1:DATA_W];
          zero_d  = (mul_acc_next[DATA_W-1:0] == '0);
          state_d = StFetch1;
        end
      end
`endif

      StHalt: ;

      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (CLR) begin
      state_q     <= StIdle;
      pc_q        <= '0;
      mar_q       <= '0;
      ir_q        <= '0;
      a_q         <= '0;
      b_q         <= '0;
      carry_q     <= 1'b0;
      zero_q      <= 1'b0;
      out_q       <= '0;
      out_valid_q <= 1'b0;
`ifdef SAP_CORE_MUL_EN
      mul_acc_q    <= '0;
      mul_mcand_q  <= '0;
      mul_mplier_q <= '0;
      mul_cnt_q    <= '0;
`endif
    end else begin
      state_q     <= state_d;
      pc_q        <= pc_d;
      mar_q       <= mar_d;
      ir_q        <= ir_d;
      a_q         <= a_d;
      b_q         <= b_d;
      carry_q     <= carry_d;
      zero_q      <= zero_d;
      out_q       <= out_d;
      out_valid_q <= out_valid_d;
`ifdef SAP_CORE_MUL_EN
      mul_acc_q    <= mul_acc_d;
      mul_mcand_q  <= mul_mcand_d;
      mul_mplier_q <= mul_mplier_d;
      mul_cnt_q    <= mul_cnt_d;
`endif
    end
  end

  // RAM has no reset so programs survive CLR.
  always_ff @(posedge CLK) begin
    if (ram_we) mem[ram_waddr] <= ram_wdata;
  end

  assign out_data  = out_q;
  assign out_valid = out_valid_q;
  assign halted    = (state_q == StHalt);
  assign busy      = (state_q != StIdle) && (state_q != StHalt);
  assign pc_dbg    = pc_q;
  assign carry     = carry_q;
  assign zero      = zero_q;

endmodule

// File: tb/tb_sap_core.sv
// Directed bench for sap_core (DATA_W=8, ADDR_W=4). Programs are loaded
// through the prog_* port, executed, and their OUT stream, cycle timing and
// final flags are compared with hand-computed values.
module tb_sap_core;

  logic       CLK = 1'b0;
  logic       CLR = 1'b0;
  logic       run = 1'b0;
  logic       prog_we = 1'b0;
  logic [3:0] prog_addr = '0;
  logic [7:0] prog_data = '0;
  logic [7:0] out_data;
  logic       out_valid;
  logic       halted;
  logic       busy;
  logic [3:0] pc_dbg;
  logic       carry;
  logic       zero;

  sap_core #(
    .DATA_W(8),
    .ADDR_W(4)
  ) dut (
    .CLK      (CLK),
    .CLR      (CLR),
    .run      (run),
    .prog_we  (prog_we),
    .prog_addr(prog_addr),
    .prog_data(prog_data),
    .out_data (out_data),
    .out_valid(out_valid),
    .halted   (halted),
    .busy     (busy),
    .pc_dbg   (pc_dbg),
    .carry    (carry),
    .zero     (zero)
  );

  always #5 CLK = ~CLK;

  int n_pass  = 0;
  int n_total = 0;
  int n_fail  = 0;

  logic [7:0] img  [16];
  logic [7:0] outs [8];
  int n_out;
  int first_out;
  int halt_cyc;
  int cyc;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic do_reset();
    @(negedge CLK) CLR = 1'b1;
    @(negedge CLK) CLR = 1'b0;
  endtask

  task automatic clear_img();
    for (int i = 0; i < 16; i++) img[i] = 8'h90;  // NOP filler
  endtask

  task automatic load_img();
    for (int i = 0; i < 16; i++) begin
      @(negedge CLK);
      prog_we   = 1'b1;
      prog_addr = 4'(i);
      prog_data = img[i];
    end
    @(negedge CLK) prog_we = 1'b0;
  endtask

  task automatic write_word(input logic [3:0] addr, input logic [7:0] data);
    @(negedge CLK);
    prog_we   = 1'b1;
    prog_addr = addr;
    prog_data = data;
    @(negedge CLK) prog_we = 1'b0;
  endtask

  // Pulse run, then run until HALT or the cycle limit. Cycle 0 is the negedge
  // right after the edge that sampled run. If poke_cyc >= 0, a write of 0xFF
  // to address 9 is presented at that cycle.
  task automatic run_prog(input int limit, input int poke_cyc);
    @(negedge CLK) run = 1'b1;
    @(negedge CLK) run = 1'b0;
    cyc = 0; n_out = 0; first_out = -1; halt_cyc = -1;
    while (!halted && cyc < limit) begin
      prog_we   = (cyc == poke_cyc);
      prog_addr = 4'h9;
      prog_data = 8'hFF;
      @(negedge CLK);
      cyc++;
      if (out_valid) begin
        if (n_out < 8) outs[n_out] = out_data;
        if (first_out < 0) first_out = cyc;
        n_out++;
      end
    end
    prog_we = 1'b0;
    if (halted) halt_cyc = cyc;
  endtask

  initial begin
    // Reset state
    do_reset();
    check("rst_out_data", out_data, 8'h00);
    check("rst_out_valid", out_valid, 1'b0);
    check("rst_halted", halted, 1'b0);
    check("rst_busy", busy, 1'b0);
    check("rst_pc", pc_dbg, 4'h0);
    check("rst_carry", carry, 1'b0);
    check("rst_zero", zero, 1'b0);

    // LDA 9; ADD A; OUT; HLT with 0x1C + 0x0E
    clear_img();
    img[0] = 8'h09; img[1] = 8'h1A; img[2] = 8'hE0; img[3] = 8'hF0;
    img[9] = 8'h1C; img[10] = 8'h0E;
    load_img();
    run_prog(60, -1);
    check("add_nout", n_out, 1);
    check("add_out", outs[0], 8'h2A);
    check("add_out_cycle", first_out, 12);
    check("add_halt_cycle", halt_cyc, 15);
    check("add_carry", carry, 1'b0);
    check("add_zero", zero, 1'b0);
    check("add_pc", pc_dbg, 4'h4);
    // HALT holds and ignores run
    @(negedge CLK) run = 1'b1;
    @(negedge CLK) run = 1'b0;
    repeat (3) @(negedge CLK);
    check("halt_hold_halted", halted, 1'b1);
    check("halt_hold_busy", busy, 1'b0);
    check("halt_hold_pc", pc_dbg, 4'h4);
    check("halt_hold_out", out_data, 8'h2A);
    check("halt_hold_valid", out_valid, 1'b0);

    // 0xF0 + 0x20 wraps with carry; JC 4 taken
    clear_img();
    img[0] = 8'h08; img[1] = 8'h19; img[2] = 8'h64; img[3] = 8'hF0;
    img[4] = 8'hE0; img[5] = 8'hF0; img[8] = 8'hF0; img[9] = 8'h20;
    load_img();
    do_reset();
    run_prog(60, -1);
    check("wrap_nout", n_out, 1);
    check("wrap_out", outs[0], 8'h10);
    check("wrap_carry", carry, 1'b1);
    check("wrap_zero", zero, 1'b0);
    check("wrap_jc_pc", pc_dbg, 4'h6);

    // SUB 0x05 - 0x05
    clear_img();
    img[0] = 8'h08; img[1] = 8'h29; img[2] = 8'hE0; img[3] = 8'hF0;
    img[8] = 8'h05; img[9] = 8'h05;
    load_img();
    do_reset();
    run_prog(60, -1);
    check("sub_eq_out", outs[0], 8'h00);
    check("sub_eq_carry", carry, 1'b1);
    check("sub_eq_zero", zero, 1'b1);

    // SUB 0x03 - 0x05 borrows
    write_word(4'h8, 8'h03);
    do_reset();
    run_prog(60, -1);
    check("sub_lt_out", outs[0], 8'hFE);
    check("sub_lt_carry", carry, 1'b0);
    check("sub_lt_zero", zero, 1'b0);

    // Countdown: LDI 3; loop{SUB E; OUT; STA F; JZ 6; JMP 1}; LDI 7; LDA F; OUT; HLT
    clear_img();
    img[0] = 8'h43; img[1] = 8'h2E; img[2] = 8'hE0; img[3] = 8'h3F;
    img[4] = 8'h76; img[5] = 8'h51; img[6] = 8'h47; img[7] = 8'h0F;
    img[8] = 8'hE0; img[9] = 8'hF0; img[14] = 8'h01; img[15] = 8'h55;
    load_img();
    do_reset();
    run_prog(300, -1);
    check("loop_nout", n_out, 4);
    check("loop_out0", outs[0], 8'h02);
    check("loop_out1", outs[1], 8'h01);
    check("loop_out2", outs[2], 8'h00);
    check("loop_sta_readback", outs[3], 8'h00);
    check("loop_carry", carry, 1'b1);
    check("loop_zero", zero, 1'b1);
    check("loop_pc", pc_dbg, 4'hA);

    // prog_we ignored while busy, honoured in HALT
    clear_img();
    img[0] = 8'h09; img[1] = 8'hE0; img[2] = 8'hF0; img[9] = 8'h11;
    load_img();
    do_reset();
    run_prog(60, 1);
    check("busy_write_ignored", outs[0], 8'h11);
    write_word(4'h9, 8'hFF);
    do_reset();
    run_prog(60, -1);
    check("halt_write_taken", outs[0], 8'hFF);

    // PC wrap: JZ 3 (not taken), LDI 0, JMP F, F: NOP -> PC 0, JZ 3 taken, OUT, HLT
    clear_img();
    img[0] = 8'h73; img[1] = 8'h40; img[2] = 8'h5F; img[3] = 8'hE0;
    img[4] = 8'hF0; img[15] = 8'h90;
    load_img();
    do_reset();
    run_prog(100, -1);
    check("pcwrap_nout", n_out, 1);
    check("pcwrap_out_cycle", first_out, 18);
    check("pcwrap_halt_cycle", halt_cyc, 21);
    check("pcwrap_pc", pc_dbg, 4'h5);

    // CLR during EXEC2 of STA: LDA C; OUT; LDI 5; STA C; LDA C; OUT; HLT
    clear_img();
    img[0] = 8'h0C; img[1] = 8'hE0; img[2] = 8'h45; img[3] = 8'h3C;
    img[4] = 8'h0C; img[5] = 8'hE0; img[6] = 8'hF0; img[12] = 8'h33;
    load_img();
    do_reset();
    @(negedge CLK) run = 1'b1;
    @(negedge CLK) run = 1'b0;
    repeat (13) @(negedge CLK);
    check("abort_busy_before", busy, 1'b1);
    check("abort_out_before", out_data, 8'h33);
    CLR = 1'b1;
    @(negedge CLK) CLR = 1'b0;
    check("abort_pc", pc_dbg, 4'h0);
    check("abort_busy", busy, 1'b0);
    check("abort_halted", halted, 1'b0);
    check("abort_out", out_data, 8'h00);
    check("abort_carry", carry, 1'b0);
    check("abort_zero", zero, 1'b0);
    repeat (2) @(negedge CLK);
    check("abort_idle_stays", busy, 1'b0);
    run_prog(80, -1);
    check("abort_rerun_nout", n_out, 2);
    check("abort_no_store", outs[0], 8'h33);
    check("abort_rerun_out", outs[1], 8'h05);
    check("abort_rerun_halt", halt_cyc, 24);

`ifdef SAP_CORE_MUL_EN
    // LDI 7; MUL 9 (0x06); OUT; HLT
    clear_img();
    img[0] = 8'h47; img[1] = 8'h89; img[2] = 8'hE0; img[3] = 8'hF0; img[9] = 8'h06;
    load_img();
    do_reset();
    run_prog(80, -1);
    check("mul_out", outs[0], 8'h2A);
    check("mul_out_cycle", first_out, 18);
    check("mul_carry", carry, 1'b0);
    check("mul_zero", zero, 1'b0);
    // LDA 8 (0x20); MUL 9 (0x10); OUT; HLT
    clear_img();
    img[0] = 8'h08; img[1] = 8'h89; img[2] = 8'hE0; img[3] = 8'hF0;
    img[8] = 8'h20; img[9] = 8'h10;
    load_img();
    do_reset();
    run_prog(80, -1);
    check("mul_ovf_out", outs[0], 8'h00);
    check("mul_ovf_carry", carry, 1'b1);
    check("mul_ovf_zero", zero, 1'b1);
`else
    // Opcode 8 is a 3-cycle NOP
    clear_img();
    img[0] = 8'h47; img[1] = 8'h89; img[2] = 8'hE0; img[3] = 8'hF0; img[9] = 8'h06;
    load_img();
    do_reset();
    run_prog(80, -1);
    check("op8_nop_out", outs[0], 8'h07);
    check("op8_nop_out_cycle", first_out, 9);
    check("op8_nop_halt_cycle", halt_cyc, 12);
`endif

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
